// File: rtl/ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader
//
// Configuration controller for the fabric's configuration flip-flop (ccff)
// scan chain. Bitstream words arrive over a valid/ready stream and are shifted
// serially, LSB first, into the chain head. The chain's capture enable is held
// high for exactly CHAIN_LEN cycles per load, after which completion is
// reported.
//
// Parameters
//   CHAIN_LEN   total ccff bits in the chain (>= 1)
//   WORD_W      bitstream word width (>= 1); bits of the last word beyond
//               CHAIN_LEN are dropped
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a load; only honoured in IDLE or DONE
//   abort        in   synchronous abort, overrides everything but reset
//   cfg_valid    in   bitstream word valid
//   cfg_data     in   bitstream word, bit 0 shifted first
//   ccff_tail    in   chain tail (readback build only)
//   cfg_ready    out  word accepted on cfg_valid & cfg_ready
//   ccff_head    out  serial bit into the chain head
//   prog_clk_en  out  chain captures ccff_head on every edge where this is 1
//   busy         out  load in progress (LOAD/SHIFT/VERIFY)
//   done         out  level, high in DONE until the next start
//   aborted      out  sticky abort flag, cleared by the next accepted start
//   rb_mismatch  out  readback parity mismatch (readback build only)
//
// Build option
//   CCFF_READBACK_EN  adds a VERIFY pass that recirculates the chain once
//                     through ccff_tail -> ccff_head and compares the parity
//                     of what came out of the tail with what was loaded.
// -----------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_data,
`ifdef CCFF_READBACK_EN
  input  logic              ccff_tail,
`endif
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              prog_clk_en,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef CCFF_READBACK_EN
  ,
  output logic              rb_mismatch
`endif
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_VERIFY = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [WORD_W-1:0] sreg_q,     sreg_d;
  logic              ccff_head_q, ccff_head_d;
  logic              aborted_q,  aborted_d;
  logic              handshake;
`ifdef CCFF_READBACK_EN
  logic              load_par_q, load_par_d;
  logic              tail_par_q, tail_par_d;
  logic              rb_mismatch_q, rb_mismatch_d;
`endif

  // Stream handshake; abort suppresses acceptance in the same cycle.
  always_comb begin
    cfg_ready = (state_q == ST_LOAD) && !abort;
    handshake = cfg_ready && cfg_valid;
  end

  // Next-state, counters, shift register and sticky flags.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    word_idx_d  = word_idx_q;
    sreg_d      = sreg_q;
    aborted_d   = aborted_q;
`ifdef CCFF_READBACK_EN
    load_par_d    = load_par_q;
    tail_par_d    = tail_par_q;
    rb_mismatch_d = rb_mismatch_q;
`endif
    if (abort) begin
      state_d   = ST_IDLE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_LOAD;
            bit_cnt_d  = CNT_ZERO;
            word_idx_d = IDX_ZERO;
            sreg_d     = '0;
            aborted_d  = 1'b0;
`ifdef CCFF_READBACK_EN
            load_par_d    = 1'b0;
            tail_par_d    = 1'b0;
            rb_mismatch_d = 1'b0;
`endif
          end else begin
            state_d = state_q;
          end
        end
        ST_LOAD: begin
          // No timeout: LOAD waits for the source indefinitely.
          if (handshake) begin
            sreg_d     = cfg_data;
            word_idx_d = IDX_ZERO;
            state_d    = ST_SHIFT;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SHIFT: begin
          sreg_d     = sreg_q >> 1;
          word_idx_d = word_idx_q + IDX_ONE;
          bit_cnt_d  = bit_cnt_q + CNT_ONE;
`ifdef CCFF_READBACK_EN
          load_par_d = load_par_q ^ sreg_q[0];
`endif
          // The chain-length test wins, so surplus bits of the final word
          // are never shifted out.
          if (bit_cnt_q == LAST_BIT) begin
`ifdef CCFF_READBACK_EN
            state_d   = ST_VERIFY;
            bit_cnt_d = CNT_ZERO;
`else
            state_d   = ST_DONE;
`endif
          end else if (word_idx_q == LAST_IDX) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_SHIFT;
          end
        end
`ifdef CCFF_READBACK_EN
        ST_VERIFY: begin
          bit_cnt_d  = bit_cnt_q + CNT_ONE;
          tail_par_d = tail_par_q ^ ccff_tail;
          if (bit_cnt_q == LAST_BIT) begin
            // Fold in the final tail bit being seen this cycle.
            rb_mismatch_d = (tail_par_q ^ ccff_tail) != load_par_q;
            state_d       = ST_DONE;
          end else begin
            state_d = ST_VERIFY;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Head register tracks the bit that sreg will present next cycle, so the
    // first SHIFT cycle already drives bit 0 of the accepted word.
    ccff_head_d = sreg_d[0];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= CNT_ZERO;
      word_idx_q  <= IDX_ZERO;
      sreg_q      <= '0;
      ccff_head_q <= 1'b0;
      aborted_q   <= 1'b0;
`ifdef CCFF_READBACK_EN
      load_par_q    <= 1'b0;
      tail_par_q    <= 1'b0;
      rb_mismatch_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      word_idx_q  <= word_idx_d;
      sreg_q      <= sreg_d;
      ccff_head_q <= ccff_head_d;
      aborted_q   <= aborted_d;
`ifdef CCFF_READBACK_EN
      load_par_q    <= load_par_d;
      tail_par_q    <= tail_par_d;
      rb_mismatch_q <= rb_mismatch_d;
`endif
    end
  end

  // Status and chain-control decodes of the current state.
  always_comb begin
    prog_clk_en = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_LOAD: begin
        busy = 1'b1;
      end
      ST_SHIFT: begin
        busy        = 1'b1;
        prog_clk_en = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
`ifdef CCFF_READBACK_EN
      ST_VERIFY: begin
        busy        = 1'b1;
        prog_clk_en = 1'b1;
      end
`endif
      default: begin
        prog_clk_en = 1'b0;
      end
    endcase
    aborted = aborted_q;
  end

`ifdef CCFF_READBACK_EN
  // During VERIFY the tail is fed straight back to the head: a registered
  // path would add a stage to the loop and rotate the contents by one.
  always_comb begin
    if (state_q == ST_VERIFY) begin
      ccff_head = ccff_tail;
    end else begin
      ccff_head = ccff_head_q;
    end
    rb_mismatch = rb_mismatch_q;
  end
`else
  // Head bit comes straight from its register.
  always_comb begin
    ccff_head = ccff_head_q;
  end
`endif

endmodule
